// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, performs it
// after LAT cycles and returns load data or a store acknowledge on a valid/ready channel.
module dmem_responder #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_SIZE = 5,
    parameter int unsigned LAT       = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_ld,
    input  logic            req_str,
    input  logic            req_byt,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_ld,
    output logic [XLEN-1:0] rsp_data,
    output logic            busy
);

    localparam int unsigned DEPTH = 1 << ADDR_SIZE;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   str_q, str_d;
    logic                   byt_q, byt_d;
    logic [ADDR_SIZE-1:0]   idx_q, idx_d;
    logic [1:0]             lane_q, lane_d;
    logic [XLEN-1:0]        wdata_q, wdata_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_ld_q, rsp_ld_d;
    logic [XLEN-1:0]        rsp_data_q, rsp_data_d;

    logic [XLEN-1:0]        mem_q [DEPTH];
    logic [XLEN-1:0]        rd_word_c;
    logic [7:0]             rd_byte_c;
    logic                   mem_we_c;
    logic [XLEN-1:0]        mem_wdata_c;
    logic                   unused_addr_bits;

    // Address bits above the word index wrap and are intentionally ignored.
    assign unused_addr_bits = ^req_addr[XLEN-1:ADDR_SIZE+2];

    assign rd_word_c = mem_q[idx_q];
    assign rd_byte_c = rd_word_c[{lane_q, 3'b000} +: 8];

    // Next-state, access and response formation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        str_d       = str_q;
        byt_d       = byt_q;
        idx_d       = idx_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_ld_d    = rsp_ld_q;
        rsp_data_d  = rsp_data_q;
        mem_we_c    = 1'b0;
        mem_wdata_c = rd_word_c;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid && (req_ld || req_str)) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(LAT - 1);
                    str_d   = req_str;
                    byt_d   = req_byt;
                    idx_d   = req_addr[ADDR_SIZE+1:2];
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_ld_d    = ~str_q;
                    if (str_q) begin
                        mem_we_c   = 1'b1;
                        rsp_data_d = '0;
                        if (byt_q) begin
                            mem_wdata_c[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
                        end else begin
                            mem_wdata_c = wdata_q;
                        end
                    end else begin
                        rsp_data_d = byt_q ? XLEN'(rd_byte_c) : rd_word_c;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            str_q       <= 1'b0;
            byt_q       <= 1'b0;
            idx_q       <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_ld_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            str_q       <= str_d;
            byt_q       <= byt_d;
            idx_q       <= idx_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_ld_q    <= rsp_ld_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Data array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[idx_q] <= mem_wdata_c;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_ld    = rsp_ld_q;
    assign rsp_data  = rsp_data_q;

endmodule
